mem_wb_stage: RTL and testbench

- MEM/WB pipeline register and writeback select for the 16-bit, 16-register core.
- Captures the retiring instruction's results from the memory stage and picks the writeback source.
- Drives DstReg/WriteReg/DstData directly into the register file's write port.
- Also provides the halt flag and a retired-instruction counter for the testbench and top level.

---
 rtl/mem_wb_stage.sv | 87 ++++++++
 tb/tb_mem_wb_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback source select.
// Feeds the register-file write port, halt flag and retire counter.
module mem_wb_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_pc_plus2,
    input  logic [REG_AW-1:0] in_dst_reg,
    input  logic              in_reg_write,
    input  logic [1:0]        in_wb_sel,
    input  logic              in_halt,
    output logic              WriteReg,
    output logic [REG_AW-1:0] DstReg,
    output logic [DATA_W-1:0] DstData,
    output logic              wb_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_count
);

    logic              valid_q;
    logic              rw_q;
    logic              hlt_q;
    logic              rsv_q;
    logic [REG_AW-1:0] dst_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        sel_data = '0;
        unique case (in_wb_sel)
            2'b00:   sel_data = in_alu_result;
            2'b01:   sel_data = in_mem_data;
            2'b10:   sel_data = in_pc_plus2;
            default: sel_data = '0;
        endcase
    end

    // Once halted, only reset can move the stage again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            rw_q          <= 1'b0;
            hlt_q         <= 1'b0;
            rsv_q         <= 1'b0;
            dst_q         <= '0;
            data_q        <= '0;
            halted        <= 1'b0;
            retired_count <= '0;
        end else if (!halted) begin
            if (flush) begin
                valid_q <= 1'b0;
                rw_q    <= 1'b0;
                hlt_q   <= 1'b0;
                rsv_q   <= 1'b0;
                dst_q   <= '0;
                data_q  <= '0;
            end else if (!stall) begin
                valid_q <= in_valid;
                rw_q    <= in_reg_write;
                hlt_q   <= in_halt;
                rsv_q   <= (in_wb_sel == 2'b11);
                dst_q   <= in_dst_reg;
                data_q  <= sel_data;
                if (in_valid) begin
                    if (retired_count != '1)
                        retired_count <= retired_count + CNT_W'(1);
                    if (in_halt)
                        halted <= 1'b1;
                end
            end
        end
    end

    assign WriteReg = valid_q & rw_q & ~hlt_q & ~rsv_q & ~halted;
    assign DstReg   = dst_q;
    assign DstData  = data_q;
    assign wb_valid = valid_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed table,
// hand-written corner sequences and a randomized model comparison.
module tb_mem_wb_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, in_valid, in_reg_write, in_halt;
    logic [15:0] in_alu_result, in_mem_data, in_pc_plus2;
    logic [3:0]  in_dst_reg;
    logic [1:0]  in_wb_sel;

    logic        wr, v, h;
    logic [3:0]  dst;
    logic [15:0] data, cnt;
    logic        wr4, v4, h4;
    logic [3:0]  dst4, cnt4;
    logic [15:0] data4;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_alu_result(in_alu_result),
        .in_mem_data(in_mem_data), .in_pc_plus2(in_pc_plus2),
        .in_dst_reg(in_dst_reg), .in_reg_write(in_reg_write),
        .in_wb_sel(in_wb_sel), .in_halt(in_halt),
        .WriteReg(wr), .DstReg(dst), .DstData(data),
        .wb_valid(v), .halted(h), .retired_count(cnt)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_alu_result(in_alu_result),
        .in_mem_data(in_mem_data), .in_pc_plus2(in_pc_plus2),
        .in_dst_reg(in_dst_reg), .in_reg_write(in_reg_write),
        .in_wb_sel(in_wb_sel), .in_halt(in_halt),
        .WriteReg(wr4), .DstReg(dst4), .DstData(data4),
        .wb_valid(v4), .halted(h4), .retired_count(cnt4)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: expected visible outputs derived from the rules.
    int m_valid, m_we, m_dst, m_data, m_halted, m_cnt;

    function automatic int sat(input int c, input int w);
        return (c > (1 << w) - 1) ? (1 << w) - 1 : c;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_dst = 0; m_data = 0;
        m_halted = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        int src [4];
        if (m_halted != 0) return;
        if (flush) begin
            m_valid = 0; m_we = 0; m_dst = 0; m_data = 0;
        end else if (!stall) begin
            src[0] = int'(in_alu_result);
            src[1] = int'(in_mem_data);
            src[2] = int'(in_pc_plus2);
            src[3] = 0;
            m_valid = int'(in_valid);
            m_dst   = int'(in_dst_reg);
            m_data  = src[in_wb_sel];
            m_we    = (in_valid && in_reg_write && !in_halt
                       && in_wb_sel != 2'b11) ? 1 : 0;
            if (in_valid) begin
                m_cnt++;
                if (in_halt) m_halted = 1;
            end
        end
    endtask

    task automatic check_model(input string t);
        chk({t, ".we"},    32'(wr),    32'(m_we));
        chk({t, ".dst"},   32'(dst),   32'(m_dst));
        chk({t, ".data"},  32'(data),  32'(m_data));
        chk({t, ".valid"}, 32'(v),     32'(m_valid));
        chk({t, ".halt"},  32'(h),     32'(m_halted));
        chk({t, ".cnt"},   32'(cnt),   32'(sat(m_cnt, 16)));
        chk({t, ".cnt4"},  32'(cnt4),  32'(sat(m_cnt, 4)));
        chk({t, ".we4"},   32'(wr4),   32'(m_we));
        chk({t, ".data4"}, 32'(data4), 32'(m_data));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string t);
        model_edge();
        step();
        check_model(t);
    endtask

    task automatic set_in(input logic vl, input logic [3:0] d,
                          input logic [1:0] sel, input logic [15:0] alu,
                          input logic rw, input logic hl);
        stall = 0; flush = 0;
        in_valid = vl; in_dst_reg = d; in_wb_sel = sel;
        in_alu_result = alu; in_mem_data = ~alu;
        in_pc_plus2 = alu ^ 16'h5a5a;
        in_reg_write = rw; in_halt = hl;
    endtask

    task automatic rand_inputs();
        in_valid      = ($urandom_range(0, 3) != 0);
        in_alu_result = 16'($urandom);
        in_mem_data   = 16'($urandom);
        in_pc_plus2   = 16'($urandom);
        in_dst_reg    = 4'($urandom);
        in_wb_sel     = 2'($urandom);
        in_reg_write  = ($urandom_range(0, 3) != 0);
        in_halt       = ($urandom_range(0, 59) == 0);
        stall         = ($urandom_range(0, 4) == 0);
        flush         = ($urandom_range(0, 7) == 0);
    endtask

    task automatic do_reset();
        rand_inputs();
        rst = 1'b1;
        #20;
        chk("rst.we",   32'(wr),   0);
        chk("rst.dst",  32'(dst),  0);
        chk("rst.data", 32'(data), 0);
        chk("rst.v",    32'(v),    0);
        chk("rst.h",    32'(h),    0);
        chk("rst.cnt",  32'(cnt),  0);
        chk("rst.cnt4", 32'(cnt4), 0);
        #20;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        st, fl, vl;
        logic [3:0]  d;
        logic [1:0]  sel;
        logic [15:0] alu, mem, pc;
        logic        rw, hl;
        logic        e_we;
        logic [3:0]  e_dst;
        logic [15:0] e_data;
        logic        e_v;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(
        input logic st, fl, vl, input logic [3:0] d,
        input logic [1:0] sel, input logic [15:0] alu, mem, pc,
        input logic rw, e_we, input logic [3:0] e_dst,
        input logic [15:0] e_data, input logic e_v,
        input logic [15:0] e_cnt);
        vec_t r;
        r.st = st; r.fl = fl; r.vl = vl; r.d = d; r.sel = sel;
        r.alu = alu; r.mem = mem; r.pc = pc; r.rw = rw; r.hl = 1'b0;
        r.e_we = e_we; r.e_dst = e_dst; r.e_data = e_data;
        r.e_v = e_v; r.e_cnt = e_cnt;
        return r;
    endfunction

    vec_t tbl [11];

    initial begin
        rst = 1'b1;
        tbl[0]  = mk(0,0,1,4'd1, 2'b00,16'h1234,16'h0bad,16'h0bee,1, 1,4'd1, 16'h1234,1,16'd1);
        tbl[1]  = mk(0,0,1,4'd2, 2'b01,16'h0bad,16'h4321,16'h0bee,1, 1,4'd2, 16'h4321,1,16'd2);
        tbl[2]  = mk(0,0,1,4'd15,2'b10,16'h0bad,16'h0bad,16'h0102,1, 1,4'd15,16'h0102,1,16'd3);
        tbl[3]  = mk(0,0,1,4'd5, 2'b11,16'h7777,16'h8888,16'h9999,1, 0,4'd5, 16'h0000,1,16'd4);
        tbl[4]  = mk(0,0,1,4'd0, 2'b00,16'hf00f,16'h0bad,16'h0bee,1, 1,4'd0, 16'hf00f,1,16'd5);
        tbl[5]  = mk(0,0,1,4'd9, 2'b00,16'habcd,16'h0bad,16'h0bee,1, 1,4'd9, 16'habcd,1,16'd6);
        tbl[6]  = mk(1,0,1,4'd3, 2'b00,16'h1111,16'h2222,16'h3333,1, 1,4'd9, 16'habcd,1,16'd6);
        tbl[7]  = mk(1,0,1,4'd3, 2'b01,16'h1111,16'h2222,16'h3333,1, 1,4'd9, 16'habcd,1,16'd6);
        tbl[8]  = mk(1,0,1,4'd3, 2'b10,16'h1111,16'h2222,16'h3333,1, 1,4'd9, 16'habcd,1,16'd6);
        tbl[9]  = mk(1,1,1,4'd3, 2'b00,16'h1111,16'h2222,16'h3333,1, 0,4'd0, 16'h0000,0,16'd6);
        tbl[10] = mk(0,0,0,4'd7, 2'b00,16'h7777,16'h2222,16'h3333,1, 0,4'd7, 16'h7777,0,16'd6);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            in_valid = 0; stall = 0; flush = 0;
            cyc("idle");
        end

        // Directed source-select / reserved / R0 / stall / flush table.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            stall = tbl[i].st; flush = tbl[i].fl;
            in_valid = tbl[i].vl; in_dst_reg = tbl[i].d;
            in_wb_sel = tbl[i].sel; in_alu_result = tbl[i].alu;
            in_mem_data = tbl[i].mem; in_pc_plus2 = tbl[i].pc;
            in_reg_write = tbl[i].rw; in_halt = tbl[i].hl;
            model_edge();
            step();
            chk($sformatf("tbl%0d.we", i),   32'(wr),   32'(tbl[i].e_we));
            chk($sformatf("tbl%0d.dst", i),  32'(dst),  32'(tbl[i].e_dst));
            chk($sformatf("tbl%0d.data", i), 32'(data), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d.v", i),    32'(v),    32'(tbl[i].e_v));
            chk($sformatf("tbl%0d.cnt", i),  32'(cnt),  32'(tbl[i].e_cnt));
        end

        // Halt freezes the stage until reset.
        do_reset();
        set_in(1, 4'd2, 2'b00, 16'h2222, 1, 0);
        cyc("pre_hlt");
        set_in(1, 4'd4, 2'b00, 16'h4444, 1, 1);
        cyc("hlt");
        chk("hlt.halted", 32'(h), 1);
        chk("hlt.we", 32'(wr), 0);
        chk("hlt.cnt", 32'(cnt), 2);
        for (int i = 0; i < 5; i++) begin
            set_in(1, 4'd6, 2'b00, 16'h5555, 1, 0);
            cyc("halted");
        end
        chk("halted.cnt", 32'(cnt), 2);
        chk("halted.dst", 32'(dst), 4);
        do_reset();
        step();
        chk("post_rst.halted", 32'(h), 0);

        // Flush beats a valid HLT at the input.
        set_in(1, 4'd4, 2'b00, 16'h4444, 1, 1);
        flush = 1;
        cyc("flush_hlt");
        chk("flush_hlt.halted", 32'(h), 0);
        chk("flush_hlt.cnt", 32'(cnt), 0);

        // Counter saturation on the narrow-counter instance.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_in(1, 4'($urandom), 2'b00, 16'($urandom), 1, 0);
            cyc("sat");
        end
        chk("sat.cnt4", 32'(cnt4), 15);
        chk("sat.cnt", 32'(cnt), 20);

        // Random traffic with occasional asynchronous resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            rand_inputs();
            cyc("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
